// File: rtl/fpu_share_arbiter_pkg.sv
// Shared FPU opcodes, rounding mode, quiet-NaN constant and the arbiter state encoding.
// Imported by every file of the shared-FPU arbiter.
package fpu_pkg;

   localparam logic [2:0]  FPU_ADD       = 3'b000;
   localparam logic [2:0]  FPU_SUB       = 3'b001;
   localparam logic [2:0]  FPU_MUL       = 3'b010;
   localparam logic [2:0]  FPU_DIV       = 3'b011;

   localparam logic [1:0]  RMODE_NEAREST = 2'b00;

   localparam logic [63:0] FP64_QNAN     = 64'h7FF8000000000000;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

endpackage

// File: rtl/fpu_share_arbiter_if.sv
// Requester-side bundle of the shared-FPU arbiter: request levels, packed operands, grant/done and result.
// The arbiter takes the slave modport; the requester side takes master.
interface fpu_share_arbiter_if #(
   parameter int N_REQ = 4
);
   logic [N_REQ-1:0]    req;
   logic [3*N_REQ-1:0]  req_op;
   logic [64*N_REQ-1:0] req_opa;
   logic [64*N_REQ-1:0] req_opb;
   logic [N_REQ-1:0]    gnt;
   logic [N_REQ-1:0]    done;
   logic [63:0]         result;
   logic                busy;

   modport master (
      output req, req_op, req_opa, req_opb,
      input  gnt, done, result, busy
   );

   modport slave (
      input  req, req_op, req_opa, req_opb,
      output gnt, done, result, busy
   );
endinterface

// File: rtl/fpu_share_arbiter_picker.sv
// Combinational round-robin select: first set req bit at or above rr_ptr, wrapping to 0.
// Zero latency; any is low and gnt_next is zero when no request is pending.
module rr_picker #(
   parameter  int N_REQ = 4,
   localparam int IW    = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IW-1:0]    rr_ptr,
   output logic [N_REQ-1:0] gnt_next,
   output logic [IW-1:0]    index,
   output logic             any
);

   int pos;

   always_comb begin
      gnt_next = '0;
      index    = '0;
      any      = 1'b0;
      pos      = 0;
      for (int k = 0; k < N_REQ; k++) begin
         pos = int'(rr_ptr) + k;
         if (pos >= N_REQ) pos = pos - N_REQ;
         if (!any && req[pos]) begin
            any           = 1'b1;
            index         = IW'(pos);
            gnt_next[pos] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fpu_share_arbiter.sv
// Shares one FPU among N_REQ requesters: round-robin grant, operand latch, one-cycle enable, result steering.
// Issue-to-done is FPU latency + 2; requesters hold req until done. `define FPU_TIMEOUT_EN adds a watchdog.
module fpu_share_arbiter
   import fpu_pkg::*;
#(
   parameter int         N_REQ       = 4,
   parameter logic [1:0] RMODE       = RMODE_NEAREST,
   parameter int         TIMEOUT_CYC = 255
) (
   input  logic                clk_operation,
   input  logic                rst,
   fpu_share_arbiter_if.slave  rq,
   output logic                fpu_enable,
   output logic [2:0]          fpu_op,
   output logic [1:0]          fpu_rmode,
   output logic [63:0]         fpu_opa,
   output logic [63:0]         fpu_opb,
   input  logic [63:0]         fpu_out,
   input  logic                fpu_ready,
   output logic                timeout_err
);

   localparam int IW = $clog2(N_REQ);

   state_t           state, state_next;
   logic [IW-1:0]    rr_ptr;
   logic [IW-1:0]    gnt_idx;
   logic [IW-1:0]    pick_idx;
   logic [N_REQ-1:0] pick_oh;
   logic             pick_any;
   logic             ready_q;
   logic             complete;
   logic             expire;

   rr_picker #(.N_REQ(N_REQ)) u_picker (
      .req      (rq.req),
      .rr_ptr   (rr_ptr),
      .gnt_next (pick_oh),
      .index    (pick_idx),
      .any      (pick_any)
   );

   // Only a rising edge of ready counts as completion.
   assign complete  = (state == WAIT) && fpu_ready && !ready_q;
   assign fpu_rmode = RMODE;

`ifdef FPU_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYC + 1);
   logic [CW-1:0] tmo_cnt;

   always_ff @(posedge clk_operation) begin
      if (rst)                 tmo_cnt <= '0;
      else if (state == ISSUE) tmo_cnt <= '0;
      else if (state == WAIT)  tmo_cnt <= tmo_cnt + 1'b1;
   end

   // Fires on the edge where the WAIT count would reach TIMEOUT_CYC.
   assign expire = (state == WAIT) && !complete && (tmo_cnt == CW'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk_operation) begin
      if (rst)         timeout_err <= 1'b0;
      else if (expire) timeout_err <= 1'b1;
   end
`else
   assign expire      = 1'b0;
   assign timeout_err = 1'b0 && (TIMEOUT_CYC != 0);
`endif

   always_ff @(posedge clk_operation) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (pick_any) state_next = ISSUE;
         ISSUE:   state_next = WAIT;
         WAIT:    if (complete || expire) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      fpu_enable = 1'b0;
      rq.busy    = 1'b0;
      if (state == ISSUE) fpu_enable = 1'b1;
      if (state != IDLE)  rq.busy    = 1'b1;
   end

   always_ff @(posedge clk_operation) begin
      if (rst) begin
         rr_ptr    <= '0;
         gnt_idx   <= '0;
         rq.gnt    <= '0;
         rq.done   <= '0;
         rq.result <= '0;
         fpu_op    <= '0;
         fpu_opa   <= '0;
         fpu_opb   <= '0;
         ready_q   <= 1'b0;
      end else begin
         rq.done <= '0;
         ready_q <= (state == ISSUE) ? 1'b0 : fpu_ready;
         case (state)
            IDLE: begin
               if (pick_any) begin
                  rq.gnt  <= pick_oh;
                  gnt_idx <= pick_idx;
                  fpu_op  <= rq.req_op[3*int'(pick_idx) +: 3];
                  fpu_opa <= rq.req_opa[64*int'(pick_idx) +: 64];
                  fpu_opb <= rq.req_opb[64*int'(pick_idx) +: 64];
               end
            end
            WAIT: begin
               if (complete || expire) begin
                  rq.result <= complete ? fpu_out : FP64_QNAN;
                  rq.done   <= rq.gnt;
                  rq.gnt    <= '0;
                  rr_ptr    <= (gnt_idx == IW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
